// File: rtl/id_stage_pkg.sv
// RV32I instruction constants, decode tables and immediate helpers shared by
// the decode stage and its register file.
package RV32I_Inst_Pkg;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_sel_e;
  typedef enum logic [1:0] {OP1_ZERO, OP1_RS1, OP1_PC} op1_sel_e;
  typedef enum logic [1:0] {OP2_ZERO, OP2_RS2, OP2_IMM, OP2_FOUR} op2_sel_e;

  typedef struct packed {
    logic     legal;
    logic     writes_rd;
    op1_sel_e op1_sel;
    op2_sel_e op2_sel;
    imm_sel_e imm_sel;
  } dec_t;

  function automatic logic rs1_used(input logic [6:0] opc);
    case (opc)
      OPC_OP, OPC_BRANCH, OPC_STORE, OPC_OP_IMM, OPC_LOAD, OPC_JALR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic rs2_used(input logic [6:0] opc);
    case (opc)
      OPC_OP, OPC_BRANCH, OPC_STORE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Unknown opcodes fall through to an all-zero, non-writing NOP decode.
  function automatic dec_t decode(input logic [6:0] opc);
    dec_t d;
    d = '{1'b0, 1'b0, OP1_ZERO, OP2_ZERO, IMM_NONE};
    case (opc)
      OPC_OP:                         d = '{1'b1, 1'b1, OP1_RS1, OP2_RS2, IMM_NONE};
      OPC_BRANCH:                     d = '{1'b1, 1'b0, OP1_RS1, OP2_RS2, IMM_B};
      OPC_STORE:                      d = '{1'b1, 1'b0, OP1_RS1, OP2_RS2, IMM_S};
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: d = '{1'b1, 1'b1, OP1_RS1, OP2_IMM, IMM_I};
      OPC_LUI:                        d = '{1'b1, 1'b1, OP1_ZERO, OP2_IMM, IMM_U};
      OPC_AUIPC:                      d = '{1'b1, 1'b1, OP1_PC, OP2_IMM, IMM_U};
      OPC_JAL:                        d = '{1'b1, 1'b1, OP1_PC, OP2_FOUR, IMM_J};
      default: ;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] imm_gen(input logic [31:0] i, input imm_sel_e sel);
    case (sel)
      IMM_I:   return {{20{i[31]}}, i[31:20]};
      IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   return {i[31:12], 12'b0};
      IMM_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return 32'b0;
    endcase
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// Decode-to-ID/EX bundle: the values the ID/EX register captures each cycle.
interface id_stage_if #(parameter int XLEN = 32);
  // Capture rules: ID/EX loads these every cycle; bubble_o from the stage turns
  // that capture into a NOP, and stall_n_o low holds PC and IF/ID so the same
  // instruction is presented again next cycle.
  logic [XLEN-1:0] instr_addr_id;
  logic [XLEN-1:0] instr_id;
  logic [XLEN-1:0] operand1_id;
  logic [XLEN-1:0] operand2_id;
  logic            reg_wen_id;

  modport master (output instr_addr_id, instr_id, operand1_id, operand2_id, reg_wen_id);
  modport slave  (input  instr_addr_id, instr_id, operand1_id, operand2_id, reg_wen_id);
endinterface

// File: rtl/id_stage_reg_file.sv
// 31 x XLEN architectural registers (x0 hard-wired to zero), two combinational
// read ports, one write port, synchronous active-high clear.
module reg_file
  import RV32I_Inst_Pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_sync,
  input  logic [4:0]      raddr1_i,
  input  logic [4:0]      raddr2_i,
  output logic [XLEN-1:0] rdata1_o,
  output logic [XLEN-1:0] rdata2_o,
  input  logic            we_i,
  input  logic [4:0]      waddr_i,
  input  logic [XLEN-1:0] wdata_i
);

  logic [XLEN-1:0] regs_q [1:31];

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      for (int i = 1; i < 32; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != 5'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == 5'd0) ? '0 : regs_q[raddr1_i];
  assign rdata2_o = (raddr2_i == 5'd0) ? '0 : regs_q[raddr2_i];

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: operand read/forward, immediate select, load-use stall.
// Build option ID_FORWARD_EN enables EX/MEM forwarding; without it the stage stalls on EX/MEM producers.
module id_stage
  import RV32I_Inst_Pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_sync,
  input  logic [XLEN-1:0] instr_addr_if,
  input  logic [31:0]     instr_if,
  input  logic            flush_id,
  input  logic [31:0]     instr_ex,
  input  logic            reg_wen_ex,
  input  logic [XLEN-1:0] rd_data_ex,
  input  logic            reg_wen_mem,
  input  logic [4:0]      rd_addr_mem,
  input  logic [XLEN-1:0] rd_data_mem,
  input  logic            reg_wen_wb,
  input  logic [4:0]      rd_addr_wb,
  input  logic [XLEN-1:0] rd_data_wb,
  id_stage_if.master      id_o,
  output logic            stall_n_o,
  output logic            bubble_o
);

  logic [6:0]      opc;
  logic [4:0]      rs1, rs2, rd, rd_ex;
  logic            use1, use2, load_use, hazard;
  logic [XLEN-1:0] rf_rdata1, rf_rdata2, rs1_val, rs2_val, imm;
  dec_t            dec;

  assign opc   = instr_if[6:0];
  assign rd    = instr_if[11:7];
  assign rs1   = instr_if[19:15];
  assign rs2   = instr_if[24:20];
  assign rd_ex = instr_ex[11:7];
  assign dec   = decode(opc);
  assign imm   = imm_gen(instr_if, dec.imm_sel);
  assign use1  = rs1_used(opc) && (rs1 != 5'd0);
  assign use2  = rs2_used(opc) && (rs2 != 5'd0);

  reg_file #(.XLEN(XLEN)) u_rf (
    .clk      (clk),
    .rst_sync (rst_sync),
    .raddr1_i (rs1),
    .raddr2_i (rs2),
    .rdata1_o (rf_rdata1),
    .rdata2_o (rf_rdata2),
    .we_i     (reg_wen_wb),
    .waddr_i  (rd_addr_wb),
    .wdata_i  (rd_data_wb)
  );

  assign load_use = (instr_ex[6:0] == OPC_LOAD) && (rd_ex != 5'd0) &&
                    ((use1 && (rs1 == rd_ex)) || (use2 && (rs2 == rd_ex)));

`ifdef ID_FORWARD_EN
  logic unused_ok;
  assign unused_ok = ^instr_ex[31:12];
  assign hazard    = load_use;

  // EX is the younger producer, so it wins over MEM; WB is write-through.
  always_comb begin
    rs1_val = rf_rdata1;
    if (rs1 == 5'd0)                               rs1_val = '0;
    else if (reg_wen_ex && (rd_ex == rs1))         rs1_val = rd_data_ex;
    else if (reg_wen_mem && (rd_addr_mem == rs1))  rs1_val = rd_data_mem;
    else if (reg_wen_wb && (rd_addr_wb == rs1))    rs1_val = rd_data_wb;
  end

  always_comb begin
    rs2_val = rf_rdata2;
    if (rs2 == 5'd0)                               rs2_val = '0;
    else if (reg_wen_ex && (rd_ex == rs2))         rs2_val = rd_data_ex;
    else if (reg_wen_mem && (rd_addr_mem == rs2))  rs2_val = rd_data_mem;
    else if (reg_wen_wb && (rd_addr_wb == rs2))    rs2_val = rd_data_wb;
  end
`else
  logic unused_ok, raw_ex, raw_mem;
  assign unused_ok = ^{instr_ex[31:12], rd_data_ex, rd_data_mem};
  assign raw_ex    = reg_wen_ex && (rd_ex != 5'd0) &&
                     ((use1 && (rs1 == rd_ex)) || (use2 && (rs2 == rd_ex)));
  assign raw_mem   = reg_wen_mem && (rd_addr_mem != 5'd0) &&
                     ((use1 && (rs1 == rd_addr_mem)) || (use2 && (rs2 == rd_addr_mem)));
  assign hazard    = load_use || raw_ex || raw_mem;

  always_comb begin
    rs1_val = rf_rdata1;
    if (rs1 == 5'd0)                             rs1_val = '0;
    else if (reg_wen_wb && (rd_addr_wb == rs1))  rs1_val = rd_data_wb;
  end

  always_comb begin
    rs2_val = rf_rdata2;
    if (rs2 == 5'd0)                             rs2_val = '0;
    else if (reg_wen_wb && (rd_addr_wb == rs2))  rs2_val = rd_data_wb;
  end
`endif

  always_comb begin
    id_o.instr_addr_id = instr_addr_if;
    id_o.instr_id      = dec.legal ? instr_if : INST_NOP;
    id_o.reg_wen_id    = dec.writes_rd && (rd != 5'd0);
    id_o.operand1_id   = '0;
    id_o.operand2_id   = '0;
    stall_n_o          = !hazard;
    bubble_o           = hazard;
    case (dec.op1_sel)
      OP1_RS1: id_o.operand1_id = rs1_val;
      OP1_PC:  id_o.operand1_id = instr_addr_if;
      default: ;
    endcase
    case (dec.op2_sel)
      OP2_RS2:  id_o.operand2_id = rs2_val;
      OP2_IMM:  id_o.operand2_id = imm;
      OP2_FOUR: id_o.operand2_id = 32'd4;
      default: ;
    endcase
    // A squash overrides any hazard; reset overrides both on the control side.
    if (flush_id) begin
      id_o.instr_id    = INST_NOP;
      id_o.reg_wen_id  = 1'b0;
      id_o.operand1_id = '0;
      id_o.operand2_id = '0;
      stall_n_o        = 1'b1;
      bubble_o         = 1'b0;
    end
    if (rst_sync) begin
      id_o.reg_wen_id = 1'b0;
      stall_n_o       = 1'b1;
      bubble_o        = 1'b1;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed, table-driven bench for id_stage; expectations follow ID_FORWARD_EN if defined.
module tb_id_stage;
  import RV32I_Inst_Pkg::*;

`ifdef ID_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_sync;
  logic [31:0] instr_addr_if, instr_if, instr_ex, rd_data_ex, rd_data_mem, rd_data_wb;
  logic        flush_id, reg_wen_ex, reg_wen_mem, reg_wen_wb;
  logic [4:0]  rd_addr_mem, rd_addr_wb;
  logic        stall_n_o, bubble_o;

  int checks = 0;
  int errors = 0;

  id_stage_if #(.XLEN(32)) id_bus ();

  id_stage #(.XLEN(32)) dut (
    .clk           (clk),
    .rst_sync      (rst_sync),
    .instr_addr_if (instr_addr_if),
    .instr_if      (instr_if),
    .flush_id      (flush_id),
    .instr_ex      (instr_ex),
    .reg_wen_ex    (reg_wen_ex),
    .rd_data_ex    (rd_data_ex),
    .reg_wen_mem   (reg_wen_mem),
    .rd_addr_mem   (rd_addr_mem),
    .rd_data_mem   (rd_data_mem),
    .reg_wen_wb    (reg_wen_wb),
    .rd_addr_wb    (rd_addr_wb),
    .rd_data_wb    (rd_data_wb),
    .id_o          (id_bus),
    .stall_n_o     (stall_n_o),
    .bubble_o      (bubble_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] pc, instr, ex_instr, ex_data, mem_data, wb_data;
    logic        flush, ex_wen, mem_wen, wb_wen;
    logic [4:0]  mem_addr, wb_addr;
    logic [31:0] e_instr, e_op1, e_op2;
    logic        e_wen, e_stall_n, e_bubble;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic [31:0] pc, input logic [31:0] instr,
                     input logic [31:0] ex_instr, input logic ex_wen, input logic [31:0] ex_data,
                     input logic mem_wen, input logic [4:0] mem_addr, input logic [31:0] mem_data,
                     input logic wb_wen, input logic [4:0] wb_addr, input logic [31:0] wb_data,
                     input logic flush, input logic [31:0] e_instr, input logic [31:0] e_op1,
                     input logic [31:0] e_op2, input logic e_wen, input logic e_stall_n,
                     input logic e_bubble);
    vec_t v;
    v.name = name; v.pc = pc; v.instr = instr; v.flush = flush;
    v.ex_instr = ex_instr; v.ex_wen = ex_wen; v.ex_data = ex_data;
    v.mem_wen = mem_wen; v.mem_addr = mem_addr; v.mem_data = mem_data;
    v.wb_wen = wb_wen; v.wb_addr = wb_addr; v.wb_data = wb_data;
    v.e_instr = e_instr; v.e_op1 = e_op1; v.e_op2 = e_op2;
    v.e_wen = e_wen; v.e_stall_n = e_stall_n; v.e_bubble = e_bubble;
    vecs.push_back(v);
  endtask

  // driver
  task automatic drive(input vec_t v);
    instr_addr_if = v.pc;       instr_if    = v.instr;    flush_id    = v.flush;
    instr_ex      = v.ex_instr; reg_wen_ex  = v.ex_wen;   rd_data_ex  = v.ex_data;
    reg_wen_mem   = v.mem_wen;  rd_addr_mem = v.mem_addr; rd_data_mem = v.mem_data;
    reg_wen_wb    = v.wb_wen;   rd_addr_wb  = v.wb_addr;  rd_data_wb  = v.wb_data;
  endtask

  // scoreboard compare
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic check_ctrl(input string tag, input logic e_wen, input logic e_sn, input logic e_b);
    check({tag, ".reg_wen"}, 32'(id_bus.reg_wen_id), 32'(e_wen));
    check({tag, ".stall_n"}, 32'(stall_n_o), 32'(e_sn));
    check({tag, ".bubble"},  32'(bubble_o), 32'(e_b));
  endtask

  initial begin
    vec_t v;
    // name pc instr | ex_instr wen data | mem wen addr data | wb wen addr data | flush | e_instr op1 op2 wen stall_n bubble
    add("rd_x5_post_rst", 0, 32'hFFF28313, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0,
        32'hFFF28313, 0, 32'hFFFFFFFF, 1, 1, 0);
    add("add_zero", 0, 32'h003100B3, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0,
        32'h003100B3, 0, 0, 1, 1, 0);
    add("wb_bypass", 0, 32'hFFF28313, NOP, 0, 0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0,
        32'hFFF28313, 32'hDEADBEEF, 32'hFFFFFFFF, 1, 1, 0);
    add("rf_read", 0, 32'hFFF28313, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0,
        32'hFFF28313, 32'hDEADBEEF, 32'hFFFFFFFF, 1, 1, 0);
    add("load_use", 0, 32'h00738433, 32'h0000A383, 1, 32'h55, 0, 0, 0, 0, 0, 0, 0,
        32'h00738433, FWD ? 32'h55 : 0, FWD ? 32'h55 : 0, 1, 0, 1);
    add("load_in_mem", 0, 32'h00738433, NOP, 0, 0, 1, 7, 32'h77, 0, 0, 0, 0,
        32'h00738433, FWD ? 32'h77 : 0, FWD ? 32'h77 : 0, 1, FWD, !FWD);
    add("load_in_wb", 0, 32'h00738433, NOP, 0, 0, 0, 0, 0, 1, 7, 32'h77, 0,
        32'h00738433, 32'h77, 32'h77, 1, 1, 0);
    add("ex_mem_same_rd", 0, 32'h40048533, 32'h00100493, 1, 1, 1, 9, 2, 0, 0, 0, 0,
        32'h40048533, FWD ? 1 : 0, 0, 1, FWD, !FWD);
    add("x9_in_mem", 0, 32'h40048533, NOP, 0, 0, 1, 9, 1, 0, 0, 0, 0,
        32'h40048533, FWD ? 1 : 0, 0, 1, FWD, !FWD);
    add("x9_in_wb", 0, 32'h40048533, NOP, 0, 0, 0, 0, 0, 1, 9, 1, 0,
        32'h40048533, 1, 0, 1, 1, 0);
    add("flush_hazard", 0, 32'h00738433, 32'h0000A383, 1, 32'h55, 0, 0, 0, 0, 0, 0, 1,
        NOP, 0, 0, 0, 1, 0);
    add("lui", 0, 32'h123450B7, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0,
        32'h123450B7, 0, 32'h12345000, 1, 1, 0);
    add("jal", 32'h100, 32'h000000EF, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0,
        32'h000000EF, 32'h100, 4, 1, 1, 0);
    add("wb_x0", 0, 32'h000000B3, NOP, 0, 0, 0, 0, 0, 1, 0, 32'hFFFFFFFF, 0,
        32'h000000B3, 0, 0, 1, 1, 0);
    add("rs2_read", 0, 32'h009005B3, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0,
        32'h009005B3, 0, 1, 1, 1, 0);
    add("auipc", 32'h200, 32'h00001617, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0,
        32'h00001617, 32'h200, 32'h1000, 1, 1, 0);
    add("store", 0, 32'h0072A423, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0,
        32'h0072A423, 32'hDEADBEEF, 32'h77, 0, 1, 0);
    add("illegal", 0, 32'h00000FFF, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0,
        NOP, 0, 0, 0, 1, 0);
    add("branch", 0, 32'h00728063, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0,
        32'h00728063, 32'hDEADBEEF, 32'h77, 0, 1, 0);
    add("nop_rd0", 0, NOP, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0,
        NOP, 0, 0, 0, 1, 0);
    add("unused_rs", 0, 32'h00038437, 32'h0000A383, 1, 32'h55, 0, 0, 0, 0, 0, 0, 0,
        32'h00038437, 0, 32'h00038000, 1, 1, 0);
    add("ld_ld_1", 0, 32'h0003A403, 32'h0000A383, 1, 32'h55, 0, 0, 0, 0, 0, 0, 0,
        32'h0003A403, FWD ? 32'h55 : 32'h77, 0, 1, 0, 1);
    add("ld_ld_2", 0, 32'h0003A403, NOP, 0, 0, 1, 7, 32'h99, 0, 0, 0, 0,
        32'h0003A403, FWD ? 32'h99 : 32'h77, 0, 1, FWD, !FWD);
    add("ld_ld_3", 0, 32'h000404B3, 32'h0003A403, 1, 32'h11, 0, 0, 0, 1, 7, 32'h99, 0,
        32'h000404B3, FWD ? 32'h11 : 0, 0, 1, 0, 1);

    // Reset with a pending WB write to x5: controls forced, no write lands.
    rst_sync = 1'b1;
    v = vecs[0];
    v.instr = 32'h003100B3; v.wb_wen = 1'b1; v.wb_addr = 5'd5; v.wb_data = 32'h1234;
    drive(v);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #2;
      check_ctrl("reset", 1'b0, 1'b1, 1'b1);
    end
    @(negedge clk);
    rst_sync = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      #2;
      check({vecs[i].name, ".instr"}, id_bus.instr_id, vecs[i].e_instr);
      check({vecs[i].name, ".op1"}, id_bus.operand1_id, vecs[i].e_op1);
      check({vecs[i].name, ".op2"}, id_bus.operand2_id, vecs[i].e_op2);
      check({vecs[i].name, ".pc"}, id_bus.instr_addr_id, vecs[i].pc);
      check_ctrl(vecs[i].name, vecs[i].e_wen, vecs[i].e_stall_n, vecs[i].e_bubble);
      @(negedge clk);
    end

    // Mid-run reset clears the array (x5 held 0xDEADBEEF, x7 0x99).
    v = vecs[0];
    v.wb_wen = 1'b1; v.wb_addr = 5'd5; v.wb_data = 32'h1234;
    drive(v);
    rst_sync = 1'b1;
    #2;
    check_ctrl("mid_reset", 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    rst_sync = 1'b0;
    drive(vecs[0]);
    #2;
    check("post_reset.x5", id_bus.operand1_id, 32'h0);
    check_ctrl("post_reset", 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    v = vecs[0];
    v.instr = 32'h0072A423;
    drive(v);
    #2;
    check("post_reset.x7", id_bus.operand2_id, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
